// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants for the MIPS pipeline hazard controller: forwarding selects,
// FSM state encoding and counter widths. S_STEP exists only under DEBUG_STEP_EN.
package pipe_hazard_ctrl_pkg;

  localparam logic [1:0] FWD_NO      = 2'd0;
  localparam logic [1:0] FWD_ALU_EXE = 2'd1;
  localparam logic [1:0] FWD_WB_MEM  = 2'd2;
  localparam logic [1:0] FWD_MEM     = 2'd3;

  localparam int HOLD_W  = 4;
  localparam int TIMER_W = 8;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_RUN   = 2'd1,
`ifdef DEBUG_STEP_EN
    S_WAIT  = 2'd2,
    S_STEP  = 2'd3
`else
    S_WAIT  = 2'd2
`endif
  } state_e;

  // True when a used, non-zero source register is written by the given producer.
  function automatic logic reg_hit(logic use_op, logic [4:0] src, logic wen, logic [4:0] dst);
    return use_op && wen && (dst != 5'd0) && (src == dst);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// Per-operand forwarding select: the youngest producer (EXE) wins over MEM;
// a load still in EXE can only be served from the memory read data.
module pipe_hazard_ctrl_fwd_sel
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic       use_op,
  input  logic [4:0] src_addr,
  input  logic [4:0] regw_addr_exe,
  input  logic       wb_wen_exe,
  input  logic       load_exe,
  input  logic [4:0] regw_addr_mem,
  input  logic       wb_wen_mem,
  output logic [1:0] fwd_sel
);

  always_comb begin
    fwd_sel = FWD_NO;
    if (reg_hit(use_op, src_addr, wb_wen_exe, regw_addr_exe)) begin
      fwd_sel = load_exe ? FWD_MEM : FWD_ALU_EXE;
    end else if (reg_hit(use_op, src_addr, wb_wen_mem, regw_addr_mem)) begin
      fwd_sel = FWD_WB_MEM;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: reset warm-up, memory-wait freeze, branch flush, load-use bubble
// and forwarding selects. Defining DEBUG_STEP_EN adds single-step ports and S_STEP.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned RST_HOLD       = 4,
  parameter int unsigned MEM_TIMEOUT    = 255,
  parameter int unsigned LOAD_USE_STALL = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_data_id,
  input  logic        use_rs_id,
  input  logic        use_rt_id,
  input  logic [4:0]  regw_addr_exe,
  input  logic        wb_wen_exe,
  input  logic        wb_data_src_exe,
  input  logic [4:0]  regw_addr_mem,
  input  logic        wb_wen_mem,
  input  logic        is_branch_mem,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic        mem_ack,
`ifdef DEBUG_STEP_EN
  input  logic        step_mode,
  input  logic        step_req,
`endif
  output logic        if_rst,
  output logic        id_rst,
  output logic        exe_rst,
  output logic        mem_rst,
  output logic        wb_rst,
  output logic        if_en,
  output logic        id_en,
  output logic        exe_en,
  output logic        mem_en,
  output logic        wb_en,
  output logic [1:0]  exe_fwd_a_ctrl,
  output logic [1:0]  exe_fwd_b_ctrl,
  output logic        mem_err,
  output logic [1:0]  ctrl_state
);

  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(RST_HOLD - 1);
  localparam logic [TIMER_W-1:0] TMO       = TIMER_W'(MEM_TIMEOUT);

  state_e               state_q, state_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 mem_err_q, mem_err_d;
`ifdef DEBUG_STEP_EN
  logic                 step_req_q, step_req_d;
`endif

  logic [4:0] rs_id, rt_id;
  logic [1:0] fwd_a, fwd_b;
  logic       load_use_hit, load_use_stall, mem_stall;
  logic       unused_inst_bits;

  assign rs_id            = inst_data_id[25:21];
  assign rt_id            = inst_data_id[20:16];
  assign unused_inst_bits = ^{inst_data_id[31:26], inst_data_id[15:0]};

  pipe_hazard_ctrl_fwd_sel u_fwd_a (
    .use_op        (use_rs_id),
    .src_addr      (rs_id),
    .regw_addr_exe (regw_addr_exe),
    .wb_wen_exe    (wb_wen_exe),
    .load_exe      (wb_data_src_exe),
    .regw_addr_mem (regw_addr_mem),
    .wb_wen_mem    (wb_wen_mem),
    .fwd_sel       (fwd_a)
  );

  pipe_hazard_ctrl_fwd_sel u_fwd_b (
    .use_op        (use_rt_id),
    .src_addr      (rt_id),
    .regw_addr_exe (regw_addr_exe),
    .wb_wen_exe    (wb_wen_exe),
    .load_exe      (wb_data_src_exe),
    .regw_addr_mem (regw_addr_mem),
    .wb_wen_mem    (wb_wen_mem),
    .fwd_sel       (fwd_b)
  );

  assign load_use_hit = wb_wen_exe && wb_data_src_exe && (regw_addr_exe != 5'd0) &&
                        ((use_rs_id && (rs_id == regw_addr_exe)) ||
                         (use_rt_id && (rt_id == regw_addr_exe)));
  assign load_use_stall = (LOAD_USE_STALL != 0) && load_use_hit;
  assign mem_stall      = (mem_ren || mem_wen) && !mem_ack;

  always_comb begin
    state_d        = state_q;
    hold_d         = hold_q;
    timer_d        = timer_q;
    mem_err_d      = mem_err_q;
`ifdef DEBUG_STEP_EN
    step_req_d     = step_req;
`endif
    {if_rst, id_rst, exe_rst, mem_rst, wb_rst} = 5'b00000;
    {if_en, id_en, exe_en, mem_en, wb_en}      = 5'b00000;
    exe_fwd_a_ctrl = fwd_a;
    exe_fwd_b_ctrl = fwd_b;

    case (state_q)
      S_RESET: begin
        {if_rst, id_rst, exe_rst, mem_rst, wb_rst} = 5'b11111;
        exe_fwd_a_ctrl = FWD_NO;
        exe_fwd_b_ctrl = FWD_NO;
        if (hold_q == HOLD_LAST) begin
          hold_d  = '0;
          state_d = S_RUN;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_RUN: begin
        // Flush beats the bubble: the load being waited on is itself wrong-path.
        if (is_branch_mem) begin
          {id_rst, exe_rst, mem_rst} = 3'b111;
          {if_en, wb_en}             = 2'b11;
        end else if (load_use_stall) begin
          exe_rst         = 1'b1;
          {mem_en, wb_en} = 2'b11;
        end else begin
          {if_en, id_en, exe_en, mem_en, wb_en} = 5'b11111;
        end
        if (mem_stall) begin
          state_d = S_WAIT;
        end
`ifdef DEBUG_STEP_EN
        else if (step_mode) begin
          state_d = S_STEP;
        end
`endif
      end
      S_WAIT: begin
        if (mem_ack) begin
          state_d = S_RUN;
          timer_d = '0;
        end else if (timer_q == TMO) begin
          state_d   = S_RUN;
          timer_d   = '0;
          mem_err_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
`ifdef DEBUG_STEP_EN
      S_STEP: begin
        if (!step_mode || (step_req && !step_req_q)) begin
          state_d = S_RUN;
        end
      end
`endif
      default: state_d = S_RESET;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_RESET;
      hold_q     <= '0;
      timer_q    <= '0;
      mem_err_q  <= 1'b0;
`ifdef DEBUG_STEP_EN
      step_req_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      timer_q    <= timer_d;
      mem_err_q  <= mem_err_d;
`ifdef DEBUG_STEP_EN
      step_req_q <= step_req_d;
`endif
    end
  end

  assign mem_err    = mem_err_q;
  assign ctrl_state = state_q;

endmodule
